// File: rtl/writeback_broadcast_unit_if.sv
// Completion, wakeup and ROB-delivery signals of the writeback broadcast unit.
// The master modport is the unit itself; slave is the FU/RS/ROB side.
interface writeback_broadcast_unit_if #(
    parameter int unsigned CQ_AW = 4
);
    logic        fu1_done_valid;
    logic [5:0]  fu1_done_tag;
    logic [31:0] fu1_done_val;
    logic [5:0]  fu1_done_rob;
    logic        fu1_done_regwrite;
    logic        fu2_done_valid;
    logic [5:0]  fu2_done_tag;
    logic [31:0] fu2_done_val;
    logic [5:0]  fu2_done_rob;
    logic        fu2_done_regwrite;
    logic        fu3_done_valid;
    logic [5:0]  fu3_done_tag;
    logic [31:0] fu3_done_val;
    logic [5:0]  fu3_done_rob;
    logic        fu3_done_regwrite;
    logic        ls_done_valid;
    logic [5:0]  ls_done_tag;
    logic [31:0] ls_done_val;
    logic [5:0]  ls_done_rob;
    logic        ls_done_regwrite;

    logic        wakeup_1_valid;
    logic [5:0]  wakeup_1_tag;
    logic [31:0] wakeup_1_val;
    logic        wakeup_2_valid;
    logic [5:0]  wakeup_2_tag;
    logic [31:0] wakeup_2_val;
    logic        wakeup_3_valid;
    logic [5:0]  wakeup_3_tag;
    logic [31:0] wakeup_3_val;
    logic        wakeup_4_valid;
    logic [5:0]  wakeup_4_tag;
    logic [31:0] wakeup_4_val;

    logic        FU1_ready;
    logic        FU2_ready;
    logic        FU3_ready;
    logic        LS_ready;

    logic        rob_cmp_valid;
    logic [5:0]  rob_cmp_num;
    logic [31:0] rob_cmp_val;
    logic        rob_cmp_ready;
    logic [CQ_AW:0] cq_count;
    logic        overflow_err;

    modport master (
        input  fu1_done_valid, fu1_done_tag, fu1_done_val, fu1_done_rob, fu1_done_regwrite,
        input  fu2_done_valid, fu2_done_tag, fu2_done_val, fu2_done_rob, fu2_done_regwrite,
        input  fu3_done_valid, fu3_done_tag, fu3_done_val, fu3_done_rob, fu3_done_regwrite,
        input  ls_done_valid, ls_done_tag, ls_done_val, ls_done_rob, ls_done_regwrite,
        input  rob_cmp_ready,
        output wakeup_1_valid, wakeup_1_tag, wakeup_1_val,
        output wakeup_2_valid, wakeup_2_tag, wakeup_2_val,
        output wakeup_3_valid, wakeup_3_tag, wakeup_3_val,
        output wakeup_4_valid, wakeup_4_tag, wakeup_4_val,
        output FU1_ready, FU2_ready, FU3_ready, LS_ready,
        output rob_cmp_valid, rob_cmp_num, rob_cmp_val, cq_count, overflow_err
    );

    modport slave (
        output fu1_done_valid, fu1_done_tag, fu1_done_val, fu1_done_rob, fu1_done_regwrite,
        output fu2_done_valid, fu2_done_tag, fu2_done_val, fu2_done_rob, fu2_done_regwrite,
        output fu3_done_valid, fu3_done_tag, fu3_done_val, fu3_done_rob, fu3_done_regwrite,
        output ls_done_valid, ls_done_tag, ls_done_val, ls_done_rob, ls_done_regwrite,
        output rob_cmp_ready,
        input  wakeup_1_valid, wakeup_1_tag, wakeup_1_val,
        input  wakeup_2_valid, wakeup_2_tag, wakeup_2_val,
        input  wakeup_3_valid, wakeup_3_tag, wakeup_3_val,
        input  wakeup_4_valid, wakeup_4_tag, wakeup_4_val,
        input  FU1_ready, FU2_ready, FU3_ready, LS_ready,
        input  rob_cmp_valid, rob_cmp_num, rob_cmp_val, cq_count, overflow_err
    );
endinterface

// File: rtl/writeback_broadcast_unit.sv
// Registers FU/LS completions onto the wakeup buses and queues every completion
// for in-order, one-per-cycle delivery to the ROB.
module writeback_broadcast_unit #(
    parameter int unsigned CQ_DEPTH = 16,
    parameter int unsigned CQ_AW    = 4,
    parameter int unsigned NUM_SRC  = 4
) (
    input logic                         clk,
    input logic                         reset,
    writeback_broadcast_unit_if.master  wb_bus
);
    logic        w_src_valid [NUM_SRC];
    logic        w_src_rw    [NUM_SRC];
    logic [5:0]  w_src_tag   [NUM_SRC];
    logic [5:0]  w_src_rob   [NUM_SRC];
    logic [31:0] w_src_val   [NUM_SRC];

    assign w_src_valid[0] = wb_bus.fu1_done_valid;
    assign w_src_rw[0]    = wb_bus.fu1_done_regwrite;
    assign w_src_tag[0]   = wb_bus.fu1_done_tag;
    assign w_src_rob[0]   = wb_bus.fu1_done_rob;
    assign w_src_val[0]   = wb_bus.fu1_done_val;
    assign w_src_valid[1] = wb_bus.fu2_done_valid;
    assign w_src_rw[1]    = wb_bus.fu2_done_regwrite;
    assign w_src_tag[1]   = wb_bus.fu2_done_tag;
    assign w_src_rob[1]   = wb_bus.fu2_done_rob;
    assign w_src_val[1]   = wb_bus.fu2_done_val;
    assign w_src_valid[2] = wb_bus.fu3_done_valid;
    assign w_src_rw[2]    = wb_bus.fu3_done_regwrite;
    assign w_src_tag[2]   = wb_bus.fu3_done_tag;
    assign w_src_rob[2]   = wb_bus.fu3_done_rob;
    assign w_src_val[2]   = wb_bus.fu3_done_val;
    assign w_src_valid[3] = wb_bus.ls_done_valid;
    assign w_src_rw[3]    = wb_bus.ls_done_regwrite;
    assign w_src_tag[3]   = wb_bus.ls_done_tag;
    assign w_src_rob[3]   = wb_bus.ls_done_rob;
    assign w_src_val[3]   = wb_bus.ls_done_val;

    logic [5:0]       r_cq_rob [CQ_DEPTH];
    logic [31:0]      r_cq_val [CQ_DEPTH];
    logic [CQ_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CQ_AW:0]   r_count;
    logic             r_ready, r_overflow;
    logic             r_wk_valid [NUM_SRC];
    logic [5:0]       r_wk_tag   [NUM_SRC];
    logic [31:0]      r_wk_val   [NUM_SRC];

    logic             w_head_valid, w_deq, w_drop, w_ready_d;
    logic [CQ_AW:0]   w_free, w_n_enq, w_count_d;
    logic             w_accept  [NUM_SRC];
    logic             w_wk_fire [NUM_SRC];
    logic [CQ_AW-1:0] w_slot    [NUM_SRC];

    assign w_head_valid = (r_count != '0);
    assign w_deq        = w_head_valid & wb_bus.rob_cmp_ready;
    // A slot freed by this cycle's dequeue can be refilled in the same cycle.
    assign w_free       = (CQ_AW+1)'(CQ_DEPTH) - r_count + (CQ_AW+1)'(w_deq);

    // Sources claim consecutive tail slots in fixed priority order.
    always_comb begin
        w_n_enq = '0;
        w_drop  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_accept[i]  = 1'b0;
            w_slot[i]    = r_wr_ptr + w_n_enq[CQ_AW-1:0];
            w_wk_fire[i] = w_src_valid[i] & w_src_rw[i] & (w_src_tag[i] != '0);
            if (w_src_valid[i]) begin
                if (w_n_enq < w_free) begin
                    w_accept[i] = 1'b1;
                    w_n_enq     = w_n_enq + (CQ_AW+1)'(1);
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
        w_count_d = r_count + w_n_enq - (CQ_AW+1)'(w_deq);
        w_ready_d = (w_count_d <= (CQ_AW+1)'(CQ_DEPTH - NUM_SRC));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_accept[i]) begin
                r_cq_rob[w_slot[i]] <= w_src_rob[i];
                r_cq_val[w_slot[i]] <= w_src_val[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_wk_valid[i] <= 1'b0;
                r_wk_tag[i]   <= '0;
                r_wk_val[i]   <= '0;
            end
        end else begin
            r_wr_ptr   <= r_wr_ptr + w_n_enq[CQ_AW-1:0];
            r_rd_ptr   <= r_rd_ptr + CQ_AW'(w_deq);
            r_count    <= w_count_d;
            r_ready    <= w_ready_d;
            r_overflow <= r_overflow | w_drop;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_wk_valid[i] <= w_wk_fire[i];
                if (w_wk_fire[i]) begin
                    r_wk_tag[i] <= w_src_tag[i];
                    r_wk_val[i] <= w_src_val[i];
                end
            end
        end
    end

    assign wb_bus.wakeup_1_valid = r_wk_valid[0];
    assign wb_bus.wakeup_1_tag   = r_wk_tag[0];
    assign wb_bus.wakeup_1_val   = r_wk_val[0];
    assign wb_bus.wakeup_2_valid = r_wk_valid[1];
    assign wb_bus.wakeup_2_tag   = r_wk_tag[1];
    assign wb_bus.wakeup_2_val   = r_wk_val[1];
    assign wb_bus.wakeup_3_valid = r_wk_valid[2];
    assign wb_bus.wakeup_3_tag   = r_wk_tag[2];
    assign wb_bus.wakeup_3_val   = r_wk_val[2];
    assign wb_bus.wakeup_4_valid = r_wk_valid[3];
    assign wb_bus.wakeup_4_tag   = r_wk_tag[3];
    assign wb_bus.wakeup_4_val   = r_wk_val[3];

    assign wb_bus.FU1_ready = r_ready;
    assign wb_bus.FU2_ready = r_ready;
    assign wb_bus.FU3_ready = r_ready;
    assign wb_bus.LS_ready  = r_ready;

    // Head fields read as zero while empty so stale storage never leaks out.
    assign wb_bus.rob_cmp_valid = w_head_valid;
    assign wb_bus.rob_cmp_num   = w_head_valid ? r_cq_rob[r_rd_ptr] : '0;
    assign wb_bus.rob_cmp_val   = w_head_valid ? r_cq_val[r_rd_ptr] : '0;
    assign wb_bus.cq_count      = r_count;
    assign wb_bus.overflow_err  = r_overflow;
endmodule

// File: tb/tb_writeback_broadcast_unit.sv
// Self-checking bench: vector table, hand-written corner sequences and a
// randomized run, all compared against a queue-based reference model.
module tb_writeback_broadcast_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    writeback_broadcast_unit_if #(.CQ_AW(4)) wb_bus ();

    writeback_broadcast_unit #(
        .CQ_DEPTH (16),
        .CQ_AW    (4),
        .NUM_SRC  (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wb_bus (wb_bus)
    );

    logic        in_v   [4];
    logic        in_rw  [4];
    logic [5:0]  in_tag [4];
    logic [5:0]  in_rob [4];
    logic [31:0] in_val [4];
    logic        rob_rdy;

    assign wb_bus.fu1_done_valid = in_v[0];
    assign wb_bus.fu1_done_regwrite = in_rw[0];
    assign wb_bus.fu1_done_tag = in_tag[0];
    assign wb_bus.fu1_done_rob = in_rob[0];
    assign wb_bus.fu1_done_val = in_val[0];
    assign wb_bus.fu2_done_valid = in_v[1];
    assign wb_bus.fu2_done_regwrite = in_rw[1];
    assign wb_bus.fu2_done_tag = in_tag[1];
    assign wb_bus.fu2_done_rob = in_rob[1];
    assign wb_bus.fu2_done_val = in_val[1];
    assign wb_bus.fu3_done_valid = in_v[2];
    assign wb_bus.fu3_done_regwrite = in_rw[2];
    assign wb_bus.fu3_done_tag = in_tag[2];
    assign wb_bus.fu3_done_rob = in_rob[2];
    assign wb_bus.fu3_done_val = in_val[2];
    assign wb_bus.ls_done_valid = in_v[3];
    assign wb_bus.ls_done_regwrite = in_rw[3];
    assign wb_bus.ls_done_tag = in_tag[3];
    assign wb_bus.ls_done_rob = in_rob[3];
    assign wb_bus.ls_done_val = in_val[3];
    assign wb_bus.rob_cmp_ready = rob_rdy;

    logic        act_wk_v   [4];
    logic [5:0]  act_wk_tag [4];
    logic [31:0] act_wk_val [4];
    logic        act_ready  [4];

    assign act_wk_v[0] = wb_bus.wakeup_1_valid;
    assign act_wk_v[1] = wb_bus.wakeup_2_valid;
    assign act_wk_v[2] = wb_bus.wakeup_3_valid;
    assign act_wk_v[3] = wb_bus.wakeup_4_valid;
    assign act_wk_tag[0] = wb_bus.wakeup_1_tag;
    assign act_wk_tag[1] = wb_bus.wakeup_2_tag;
    assign act_wk_tag[2] = wb_bus.wakeup_3_tag;
    assign act_wk_tag[3] = wb_bus.wakeup_4_tag;
    assign act_wk_val[0] = wb_bus.wakeup_1_val;
    assign act_wk_val[1] = wb_bus.wakeup_2_val;
    assign act_wk_val[2] = wb_bus.wakeup_3_val;
    assign act_wk_val[3] = wb_bus.wakeup_4_val;
    assign act_ready[0] = wb_bus.FU1_ready;
    assign act_ready[1] = wb_bus.FU2_ready;
    assign act_ready[2] = wb_bus.FU3_ready;
    assign act_ready[3] = wb_bus.LS_ready;

    // Reference model: a plain queue plus the registered wakeup/ready/error state.
    typedef struct packed {
        logic [5:0]  rob;
        logic [31:0] val;
    } cmp_t;

    cmp_t        m_q [$];
    logic        m_wk_v   [4];
    logic [5:0]  m_wk_tag [4];
    logic [31:0] m_wk_val [4];
    logic        m_ready;
    logic        m_ovf;

    int n_vec;
    int n_err;

    function automatic void model_update();
        if (!reset) begin
            m_q.delete();
            m_ready = 1'b1;
            m_ovf   = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_wk_v[i]   = 1'b0;
                m_wk_tag[i] = '0;
                m_wk_val[i] = '0;
            end
        end else begin
            if (m_q.size() > 0 && rob_rdy) void'(m_q.pop_front());
            for (int i = 0; i < 4; i++) begin
                if (in_v[i]) begin
                    if (m_q.size() < 16) m_q.push_back('{rob: in_rob[i], val: in_val[i]});
                    else m_ovf = 1'b1;
                end
                m_wk_v[i] = in_v[i] && in_rw[i] && (in_tag[i] != 6'd0);
                if (m_wk_v[i]) begin
                    m_wk_tag[i] = in_tag[i];
                    m_wk_val[i] = in_val[i];
                end
            end
            m_ready = (16 - m_q.size()) >= 4;
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wk%0d_valid", i + 1), 64'(act_wk_v[i]), 64'(m_wk_v[i]));
            chk($sformatf("wk%0d_tag", i + 1), 64'(act_wk_tag[i]), 64'(m_wk_tag[i]));
            chk($sformatf("wk%0d_val", i + 1), 64'(act_wk_val[i]), 64'(m_wk_val[i]));
            chk($sformatf("ready%0d", i + 1), 64'(act_ready[i]), 64'(m_ready));
        end
        chk("cmp_valid", 64'(wb_bus.rob_cmp_valid), 64'(m_q.size() != 0));
        chk("cmp_num", 64'(wb_bus.rob_cmp_num), (m_q.size() != 0) ? 64'(m_q[0].rob) : 64'd0);
        chk("cmp_val", 64'(wb_bus.rob_cmp_val), (m_q.size() != 0) ? 64'(m_q[0].val) : 64'd0);
        chk("cq_count", 64'(wb_bus.cq_count), 64'(m_q.size()));
        chk("overflow", 64'(wb_bus.overflow_err), 64'(m_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_model();
    endtask

    task automatic idle();
        for (int i = 0; i < 4; i++) begin
            in_v[i]   = 1'b0;
            in_rw[i]  = 1'b0;
            in_tag[i] = '0;
            in_rob[i] = '0;
            in_val[i] = '0;
        end
    endtask

    task automatic set_src(input int i, input logic v, input logic rw, input logic [5:0] tag,
                           input logic [5:0] rob, input logic [31:0] val);
        in_v[i]   = v;
        in_rw[i]  = rw;
        in_tag[i] = tag;
        in_rob[i] = rob;
        in_val[i] = val;
    endtask

    task automatic drain();
        idle();
        rob_rdy = 1'b1;
        for (int c = 0; c < 64 && m_q.size() > 0; c++) step();
        chk("drain_empty", 64'(wb_bus.cq_count), 64'd0);
    endtask

    function automatic logic [3:0] wk_vec();
        return {act_wk_v[3], act_wk_v[2], act_wk_v[1], act_wk_v[0]};
    endfunction

    typedef struct packed {
        logic [3:0] v;
        logic [3:0] rw;
        logic [5:0] tag;
        logic [3:0] exp_wk;
        logic [4:0] exp_cnt;
    } vec_t;

    vec_t vecs [7];

    initial begin
        n_vec = 0;
        n_err = 0;
        // bit 0 = FU1 ... bit 3 = LS; every source in a vector uses the same tag
        vecs[0] = '{v: 4'b0001, rw: 4'b0001, tag: 6'd5,  exp_wk: 4'b0001, exp_cnt: 5'd1};
        vecs[1] = '{v: 4'b1111, rw: 4'b1111, tag: 6'd9,  exp_wk: 4'b1111, exp_cnt: 5'd4};
        vecs[2] = '{v: 4'b1111, rw: 4'b0101, tag: 6'd7,  exp_wk: 4'b0101, exp_cnt: 5'd4};
        vecs[3] = '{v: 4'b1010, rw: 4'b1111, tag: 6'd0,  exp_wk: 4'b0000, exp_cnt: 5'd2};
        vecs[4] = '{v: 4'b0110, rw: 4'b0010, tag: 6'd63, exp_wk: 4'b0010, exp_cnt: 5'd2};
        vecs[5] = '{v: 4'b0000, rw: 4'b1111, tag: 6'd3,  exp_wk: 4'b0000, exp_cnt: 5'd0};
        vecs[6] = '{v: 4'b1000, rw: 4'b1000, tag: 6'd1,  exp_wk: 4'b1000, exp_cnt: 5'd1};

        idle();
        rob_rdy = 1'b0;
        reset   = 1'b0;
        step();
        chk("rst_count", 64'(wb_bus.cq_count), 64'd0);
        chk("rst_ready", 64'(wb_bus.LS_ready), 64'd1);
        chk("rst_ovf", 64'(wb_bus.overflow_err), 64'd0);
        reset = 1'b1;

        foreach (vecs[n]) begin
            idle();
            for (int i = 0; i < 4; i++)
                set_src(i, vecs[n].v[i], vecs[n].rw[i], vecs[n].tag, 6'(10 + i), $urandom);
            rob_rdy = 1'b0;
            step();
            chk($sformatf("vec%0d_wk", n), 64'(wk_vec()), 64'(vecs[n].exp_wk));
            chk($sformatf("vec%0d_cnt", n), 64'(wb_bus.cq_count), 64'(vecs[n].exp_cnt));
            drain();
        end

        // single op
        idle();
        set_src(0, 1'b1, 1'b1, 6'd5, 6'd3, 32'h1234);
        rob_rdy = 1'b1;
        step();
        chk("single_wk_v", 64'(wb_bus.wakeup_1_valid), 64'd1);
        chk("single_wk_tag", 64'(wb_bus.wakeup_1_tag), 64'd5);
        chk("single_wk_val", 64'(wb_bus.wakeup_1_val), 64'h1234);
        chk("single_cmp_v", 64'(wb_bus.rob_cmp_valid), 64'd1);
        chk("single_cmp_num", 64'(wb_bus.rob_cmp_num), 64'd3);
        chk("single_cmp_val", 64'(wb_bus.rob_cmp_val), 64'h1234);
        idle();
        step();
        chk("single_cnt0", 64'(wb_bus.cq_count), 64'd0);
        chk("single_wk_off", 64'(wb_bus.wakeup_1_valid), 64'd0);

        // four simultaneous dones delivered in source order
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 1'b1, 6'(20 + i), 6'(10 + i), 32'(i));
        step();
        chk("four_wk", 64'(wk_vec()), 64'hF);
        idle();
        for (int j = 0; j < 4; j++) begin
            chk("four_order", 64'(wb_bus.rob_cmp_num), 64'(10 + j));
            step();
        end
        chk("four_empty", 64'(wb_bus.cq_count), 64'd0);

        // store and tag-0 load: no wakeups, still delivered
        set_src(0, 1'b1, 1'b0, 6'd9, 6'd20, 32'hAA);
        set_src(3, 1'b1, 1'b1, 6'd0, 6'd21, 32'hBB);
        step();
        chk("nowk_wk", 64'(wk_vec()), 64'd0);
        chk("nowk_first", 64'(wb_bus.rob_cmp_num), 64'd20);
        idle();
        step();
        chk("nowk_second", 64'(wb_bus.rob_cmp_num), 64'd21);
        step();
        chk("nowk_empty", 64'(wb_bus.rob_cmp_valid), 64'd0);

        // fill to full with no ROB acceptance, then drain past the ready threshold
        rob_rdy = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            for (int i = 0; i < 4; i++) set_src(i, 1'b1, 1'b1, 6'd4, 6'(4 * c + i), $urandom);
            step();
            chk("fill_cnt", 64'(wb_bus.cq_count), 64'(4 * c));
            chk("fill_ready", 64'(wb_bus.FU1_ready), 64'(c < 4));
            chk("fill_ovf", 64'(wb_bus.overflow_err), 64'd0);
        end
        idle();
        rob_rdy = 1'b1;
        for (int c = 15; c >= 12; c--) begin
            step();
            chk("unfill_cnt", 64'(wb_bus.cq_count), 64'(c));
            chk("unfill_ready", 64'(wb_bus.FU3_ready), 64'(c <= 12));
        end
        drain();

        // protocol violation at count 15: FU1 fits, FU2 dropped
        rob_rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            idle();
            for (int i = 0; i < ((c == 3) ? 3 : 4); i++) set_src(i, 1'b1, 1'b0, 6'd0, 6'(i), 32'(c));
            step();
        end
        chk("viol_pre_cnt", 64'(wb_bus.cq_count), 64'd15);
        idle();
        set_src(0, 1'b1, 1'b0, 6'd0, 6'd40, 32'h40);
        set_src(1, 1'b1, 1'b0, 6'd0, 6'd41, 32'h41);
        step();
        chk("viol_cnt", 64'(wb_bus.cq_count), 64'd16);
        chk("viol_ovf", 64'(wb_bus.overflow_err), 64'd1);
        idle();
        rob_rdy = 1'b1;
        for (int c = 0; c < 9; c++) step();
        chk("viol_sticky", 64'(wb_bus.overflow_err), 64'd1);
        chk("mid_cnt7", 64'(wb_bus.cq_count), 64'd7);

        // reset mid-stream overrides same-cycle dones
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 1'b1, 6'd12, 6'(i), 32'(i));
        reset = 1'b0;
        step();
        reset = 1'b1;
        idle();
        chk("mrst_cnt", 64'(wb_bus.cq_count), 64'd0);
        chk("mrst_cmp_v", 64'(wb_bus.rob_cmp_valid), 64'd0);
        chk("mrst_wk", 64'(wk_vec()), 64'd0);
        chk("mrst_ready", 64'(wb_bus.FU2_ready), 64'd1);
        chk("mrst_ovf", 64'(wb_bus.overflow_err), 64'd0);

        // randomized traffic, with phases of slow and fast ROB acceptance
        for (int c = 0; c < 3000; c++) begin
            int rdy_pct;
            rdy_pct = ((c / 250) % 2 == 0) ? 25 : 90;
            rob_rdy = ($urandom_range(0, 99) < rdy_pct);
            for (int i = 0; i < 4; i++) begin
                logic viol;
                viol = ($urandom_range(0, 99) < 2);
                set_src(i, (m_ready || viol) && ($urandom_range(0, 99) < 45),
                        1'($urandom), ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom),
                        6'($urandom), $urandom);
            end
            reset = ($urandom_range(0, 399) != 0);
            step();
        end

        reset = 1'b1;
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
